mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the 8-bit teaching CPU. It owns main memory and answers the controller's mem_read/mem_write strobes in RUN mode.
- In IN mode it accepts program/data bytes from the front-panel loader over a valid/ready handshake.
- In CHECK mode it steps through memory for display.
- Sits between the controller/datapath bus and the panel I/O logic.

Parameters:
- ADDR_W, 16, width of CPU address (AR).
- DATA_W, 8, byte width.
- MEM_AW, 8, implemented memory address bits; depth = 2**MEM_AW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low. Sampled on the clk rising edge only.
- cpu_state  in  2  00 IDLE, 01 IN, 10 CHECK, 11 RUN.
- addr  in  ADDR_W  AR output.
- mem_read  in  1  read strobe from controller.
- mem_write  in  1  write strobe from controller.
- wdata  in  DATA_W  bus value (bus2mem path).
- rdata  out  DATA_W  read data to bus (mem2bus path).
- ld_data  in  DATA_W  loader byte.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  responder can accept a loader byte.
- ld_count  out  MEM_AW+1  bytes loaded since entering IN.
- chk_step  in  1  single-cycle pulse: advance check pointer.
- chk_addr  out  MEM_AW  current check address.
- chk_data  out  DATA_W  mem[chk_addr], registered.
- access_err  out  1  sticky error flag.
- parity_err  out  1  sticky parity error (optional feature).

Behaviour:
- Reset (rst=0 at clk edge):
  - mode=IDLE, ld_ptr=0, ld_count=0, full=0.
  - chk_ptr=0, chk_data=0, access_err=0, parity_err=0.
  - Memory contents are not cleared.
- Mode register:
  - mode <= cpu_state every cycle, so behaviour lags cpu_state by 1 cycle.
  - On any transition into IN: ld_ptr=0, ld_count=0, full=0.
  - On any transition into CHECK: chk_ptr=0.
- IN mode:
  - ld_ready = (mode==IN) && !full.
  - Transfer when ld_valid && ld_ready at a clk edge: mem[ld_ptr] <= ld_data, ld_ptr++, ld_count++.
  - After the 2**MEM_AW-th byte, full=1 and ld_ready=0. Further ld_valid is ignored with no write.
  - ld_ptr wraps to 0 at full and is not reused until IN is re-entered.
  - ld_valid may assert before ld_ready. Data must be held stable until the transfer.
- CHECK mode:
  - chk_step high at a clk edge: chk_ptr <= chk_ptr+1, wrapping from 2**MEM_AW-1 to 0.
  - chk_data <= mem[chk_ptr] every cycle in CHECK, giving 1-cycle latency after chk_addr changes.
  - chk_data holds its value outside CHECK.
- RUN mode:
  - rdata is combinational: mem[addr[MEM_AW-1:0]] when mode==RUN && mem_read, else 0. This gives zero-latency read, because the controller loads DR in the same cycle.
  - Write: mode==RUN && mem_write at clk edge -> mem[addr[MEM_AW-1:0]] <= wdata.
  - Simultaneous mem_read && mem_write: the write executes, rdata shows pre-write data, and access_err sets.
  - An access with addr[ADDR_W-1:MEM_AW] != 0: wraps (upper bits ignored) and access_err sets.
- IDLE mode: no writes, rdata=0, ld_ready=0.
- mem_read/mem_write outside RUN are ignored. No error is flagged.
- access_err and parity_err clear only on reset.
- Reset mid-load: partial data stays in memory and counters clear.

Optional Feature:
- MEM_PARITY_EN defined:
  - Each location stores an extra even-parity bit, written on every load and RUN write.
  - A RUN read whose stored parity mismatches the data sets parity_err at the next clk edge.
  - CHECK reads do not set the flag.
- Undefined: no parity storage, and parity_err is tied to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - cpu_state encoding constants (ST_IDLE, ST_IN, ST_CHECK, ST_RUN).
  - Default DATA_W, ADDR_W, MEM_AW.
- One sub-module, mem_array:
  - Single write port.
  - Asynchronous read port for RUN.
  - Synchronous read port for CHECK.
  - Width DATA_W, or DATA_W+1 under MEM_PARITY_EN.
- Mode/pointer logic stays in mem_responder.

Test Plan:
- IN mode, send 0x11, 0x22, 0x33 with ld_valid held high -> ld_ready high, 3 transfers in 3 cycles, ld_count=3, mem[0..2]=11,22,33.
- CHECK mode, 2 chk_step pulses after the load -> chk_addr 0,1,2; chk_data 0x11, 0x22, 0x33, each 1 cycle after the address change.
- RUN, addr=0x0005, mem_write=1, wdata=0xA5; next cycle mem_read=1 -> rdata=0xA5 combinationally; access_err=0.
- RUN, addr=0x0105 with mem_read -> rdata=mem[0x05]=0xA5, access_err=1. Simultaneous read+write to 0x06 (old 0x00, wdata 0x7E) -> rdata=0x00 that cycle, mem[0x06]=0x7E after.
- MEM_AW=2, IN mode, stream 6 bytes -> ld_ready drops after 4, ld_count=4, bytes 5-6 not written. Leave and re-enter IN -> ld_count=0, ld_ready=1.
- rst=0 for 1 cycle mid-load after 2 bytes -> ld_count=0, mode=IDLE, access_err=0, mem[0..1] retained. Under MEM_PARITY_EN, corrupt the stored parity of 0x03 via backdoor, RUN read -> parity_err=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings and default widths for the teaching-CPU memory side.
package cpu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_IN    = 2'b01;
    localparam logic [1:0] ST_CHECK = 2'b10;
    localparam logic [1:0] ST_RUN   = 2'b11;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 8;
    localparam int CPU_MEM_AW = 8;

endpackage

// File: rtl/mem_responder_if.sv
// Bus bundle between controller/panel logic (master) and the memory responder (slave).
interface mem_responder_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int MEM_AW = CPU_MEM_AW
);
    logic [1:0]        cpu_state;
    logic [ADDR_W-1:0] addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] ld_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [MEM_AW:0]   ld_count;
    logic              chk_step;
    logic [MEM_AW-1:0] chk_addr;
    logic [DATA_W-1:0] chk_data;
    logic              access_err;
    logic              parity_err;

    modport master (
        output cpu_state, addr, mem_read, mem_write, wdata, ld_data, ld_valid, chk_step,
        input  rdata, ld_ready, ld_count, chk_addr, chk_data, access_err, parity_err
    );

    modport slave (
        input  cpu_state, addr, mem_read, mem_write, wdata, ld_data, ld_valid, chk_step,
        output rdata, ld_ready, ld_count, chk_addr, chk_data, access_err, parity_err
    );
endinterface

// File: rtl/mem_responder_array.sv
// Storage for mem_responder: one write port, async read port, registered read port.
module mem_array
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_DATA_W,
    parameter int AW    = CPU_MEM_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o,
    input  logic             sren_i,
    input  logic [AW-1:0]    saddr_i,
    output logic [WIDTH-1:0] sdata_o
);
    logic [WIDTH-1:0] mem_q [2**AW];
    logic [WIDTH-1:0] sdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

    // The registered port holds its last value whenever it is not enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sdata_q <= '0;
        end else if (sren_i) begin
            sdata_q <= mem_q[saddr_i];
        end
    end

    assign sdata_o = sdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory responder: front-panel load (IN), display stepping (CHECK), CPU access (RUN).
// Optional MEM_PARITY_EN macro adds a stored even-parity bit and a sticky parity_err.
module mem_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int MEM_AW = CPU_MEM_AW
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
`ifdef MEM_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    logic [1:0]        mode_q;
    logic [MEM_AW:0]   ld_count_q, ld_count_d;
    logic [MEM_AW-1:0] chk_ptr_q, chk_ptr_d;
    logic              access_err_q, access_err_d;
    logic              parity_err_q, parity_err_d;

    logic              full, ld_ready, ld_xfer, enter_in, enter_chk;
    logic              run_rd, run_wr, upper_nz;
    logic [MEM_AW-1:0] ld_ptr, addr_lo, waddr;
    logic [DATA_W-1:0] wbyte;
    logic [MW-1:0]     wword, rd_word, sd_word;

    // The load counter doubles as write pointer (low bits) and full flag (MSB),
    // so the pointer naturally wraps to 0 exactly when the array fills.
    assign full      = ld_count_q[MEM_AW];
    assign ld_ptr    = ld_count_q[MEM_AW-1:0];
    assign ld_ready  = (mode_q == ST_IN) && !full;
    assign ld_xfer   = ld_ready && bus.ld_valid;
    assign enter_in  = (bus.cpu_state == ST_IN)    && (mode_q != ST_IN);
    assign enter_chk = (bus.cpu_state == ST_CHECK) && (mode_q != ST_CHECK);

    assign run_rd   = (mode_q == ST_RUN) && bus.mem_read;
    assign run_wr   = (mode_q == ST_RUN) && bus.mem_write;
    assign addr_lo  = bus.addr[MEM_AW-1:0];
    assign upper_nz = |bus.addr[ADDR_W-1:MEM_AW];

    assign waddr = ld_xfer ? ld_ptr : addr_lo;
    assign wbyte = ld_xfer ? bus.ld_data : bus.wdata;
`ifdef MEM_PARITY_EN
    assign wword = {^wbyte, wbyte};
`else
    assign wword = wbyte;
`endif

    always_comb begin
        ld_count_d   = ld_count_q;
        chk_ptr_d    = chk_ptr_q;
        access_err_d = access_err_q;
        parity_err_d = parity_err_q;
        if (enter_in) begin
            ld_count_d = '0;
        end else if (ld_xfer) begin
            ld_count_d = ld_count_q + (MEM_AW+1)'(1);
        end
        if (enter_chk) begin
            chk_ptr_d = '0;
        end else if ((mode_q == ST_CHECK) && bus.chk_step) begin
            chk_ptr_d = chk_ptr_q + MEM_AW'(1);
        end
        if ((run_rd && run_wr) || ((run_rd || run_wr) && upper_nz)) begin
            access_err_d = 1'b1;
        end
`ifdef MEM_PARITY_EN
        if (run_rd && (^rd_word)) begin
            parity_err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q       <= ST_IDLE;
            ld_count_q   <= '0;
            chk_ptr_q    <= '0;
            access_err_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            mode_q       <= bus.cpu_state;
            ld_count_q   <= ld_count_d;
            chk_ptr_q    <= chk_ptr_d;
            access_err_q <= access_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    mem_array #(.WIDTH(MW), .AW(MEM_AW)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ld_xfer || run_wr),
        .waddr_i (waddr),
        .wdata_i (wword),
        .raddr_i (addr_lo),
        .rdata_o (rd_word),
        .sren_i  (mode_q == ST_CHECK),
        .saddr_i (chk_ptr_q),
        .sdata_o (sd_word)
    );

`ifdef MEM_PARITY_EN
    logic unused_sd_par;
    assign unused_sd_par = sd_word[DATA_W];
`endif

    // Read data is combinational so the controller can load DR in the same cycle.
    assign bus.rdata      = run_rd ? rd_word[DATA_W-1:0] : '0;
    assign bus.ld_ready   = ld_ready;
    assign bus.ld_count   = ld_count_q;
    assign bus.chk_addr   = chk_ptr_q;
    assign bus.chk_data   = sd_word[DATA_W-1:0];
    assign bus.access_err = access_err_q;
`ifdef MEM_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder (256-byte and 4-byte instances).
module tb_mem_responder;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(16), .DATA_W(8), .MEM_AW(8)) b1 ();
    mem_responder_if #(.ADDR_W(16), .DATA_W(8), .MEM_AW(2)) b2 ();

    mem_responder #(.ADDR_W(16), .DATA_W(8), .MEM_AW(8)) dut  (.clk(clk), .rst(rst), .bus(b1));
    mem_responder #(.ADDR_W(16), .DATA_W(8), .MEM_AW(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    int errors = 0;
    int checks = 0;

    // Reference memory image: what each location should hold after the writes so far.
    logic [7:0] m1 [256];
    int         cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0]  d;
        logic [15:0] a;
        int          op;
        logic        v;

        b1.cpu_state = ST_IDLE; b1.addr = '0; b1.mem_read = 0; b1.mem_write = 0;
        b1.wdata = '0; b1.ld_data = '0; b1.ld_valid = 0; b1.chk_step = 0;
        b2.cpu_state = ST_IDLE; b2.addr = '0; b2.mem_read = 0; b2.mem_write = 0;
        b2.wdata = '0; b2.ld_data = '0; b2.ld_valid = 0; b2.chk_step = 0;

        // Reset state
        step(); step();
        chk("rst_ld_ready", b1.ld_ready, 0);
        chk("rst_ld_count", b1.ld_count, 0);
        chk("rst_chk_addr", b1.chk_addr, 0);
        chk("rst_chk_data", b1.chk_data, 0);
        chk("rst_access_err", b1.access_err, 0);
        chk("rst_parity_err", b1.parity_err, 0);
        chk("rst_rdata", b1.rdata, 0);
        rst = 1;

        // IN: three bytes with ld_valid held high
        b1.cpu_state = ST_IN; b1.ld_valid = 1; b1.ld_data = 8'h11;
        step();
        chk("in_ready", b1.ld_ready, 1);
        chk("in_count0", b1.ld_count, 0);
        step(); b1.ld_data = 8'h22;
        chk("in_count1", b1.ld_count, 1);
        step(); b1.ld_data = 8'h33;
        step(); b1.ld_valid = 0;
        chk("in_count3", b1.ld_count, 3);
        m1[0] = 8'h11; m1[1] = 8'h22; m1[2] = 8'h33; cnt = 3;

        // IN: random valid gaps and random data
        for (int i = 0; i < 20; i++) begin
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            b1.ld_valid = v; b1.ld_data = d;
            step();
            if (v) begin
                m1[cnt] = d;
                cnt++;
            end
            chk("in_rand_count", b1.ld_count, cnt);
        end
        b1.ld_valid = 0;

        // CHECK: walk addresses 0..2, data follows one cycle later
        b1.cpu_state = ST_CHECK;
        step();
        chk("chk_addr0", b1.chk_addr, 0);
        step();
        chk("chk_data0", b1.chk_data, 8'h11);
        for (int k = 1; k <= 2; k++) begin
            b1.chk_step = 1;
            step();
            b1.chk_step = 0;
            chk("chk_addr_step", b1.chk_addr, k);
            step();
            chk("chk_data_step", b1.chk_data, m1[k]);
        end

        // RUN: directed writes/reads
        b1.cpu_state = ST_RUN;
        step();
        chk("chk_data_hold", b1.chk_data, 8'h33);
        b1.addr = 16'h0006; b1.wdata = 8'h00; b1.mem_write = 1;
        step();
        b1.addr = 16'h0005; b1.wdata = 8'hA5;
        step();
        b1.mem_write = 0; b1.mem_read = 1;
        #1;
        chk("run_rd_a5", b1.rdata, 8'hA5);
        chk("run_err_clean", b1.access_err, 0);
        b1.addr = 16'h0105;
        #1;
        chk("run_rd_wrap", b1.rdata, 8'hA5);
        step();
        chk("run_err_upper", b1.access_err, 1);
        b1.addr = 16'h0006; b1.wdata = 8'h7E; b1.mem_write = 1;
        #1;
        chk("run_rw_old", b1.rdata, 8'h00);
        step();
        b1.mem_write = 0;
        #1;
        chk("run_rw_new", b1.rdata, 8'h7E);
        b1.mem_read = 0;

        // RUN: fill every location, then random reads/writes with wrapping addresses
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            b1.addr = 16'(i); b1.wdata = d; b1.mem_write = 1;
            step();
            m1[i] = d;
        end
        b1.mem_write = 0;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            a  = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a[15:8] = 8'h00;
            b1.addr = a;
            if (op == 0) begin
                b1.mem_read = 1;
                #1;
                chk("run_rand_rd", b1.rdata, m1[a[7:0]]);
                step();
                b1.mem_read = 0;
            end else if (op == 1) begin
                d = 8'($urandom);
                b1.wdata = d; b1.mem_write = 1;
                step();
                b1.mem_write = 0;
                m1[a[7:0]] = d;
            end else begin
                step();
            end
        end
        chk("run_rand_parity", b1.parity_err, 0);

        // IDLE: strobes ignored
        b1.cpu_state = ST_IDLE;
        step();
        b1.addr = 16'h0007; b1.wdata = ~m1[7]; b1.mem_read = 1; b1.mem_write = 1;
        #1;
        chk("idle_rdata", b1.rdata, 0);
        chk("idle_ready", b1.ld_ready, 0);
        step();
        b1.mem_read = 0; b1.mem_write = 0; b1.cpu_state = ST_RUN;
        step();
        b1.mem_read = 1;
        #1;
        chk("idle_no_write", b1.rdata, m1[7]);
        b1.mem_read = 0;

        // Reset in the middle of a load
        b1.cpu_state = ST_IN;
        step();
        b1.ld_valid = 1; b1.ld_data = 8'hAA;
        step();
        b1.ld_data = 8'hBB;
        step();
        b1.ld_valid = 0;
        chk("mid_count2", b1.ld_count, 2);
        m1[0] = 8'hAA; m1[1] = 8'hBB;
        rst = 0;
        step();
        rst = 1;
        chk("mid_rst_count", b1.ld_count, 0);
        chk("mid_rst_ready", b1.ld_ready, 0);
        chk("mid_rst_err", b1.access_err, 0);
        chk("mid_rst_chk_data", b1.chk_data, 0);
        step();
        chk("mid_reenter_ready", b1.ld_ready, 1);
        chk("mid_reenter_count", b1.ld_count, 0);
        b1.cpu_state = ST_RUN;
        step();
        b1.mem_read = 1; b1.addr = 16'h0000;
        #1;
        chk("mid_keep0", b1.rdata, m1[0]);
        b1.addr = 16'h0001;
        #1;
        chk("mid_keep1", b1.rdata, m1[1]);
        b1.mem_read = 0;

`ifdef MEM_PARITY_EN
        dut.u_mem.mem_q[3][8] = ~dut.u_mem.mem_q[3][8];
        b1.addr = 16'h0003; b1.mem_read = 1;
        step();
        b1.mem_read = 0;
        chk("parity_err_set", b1.parity_err, 1);
`else
        chk("parity_tied", b1.parity_err, 0);
`endif

        // Small array: stream six bytes into four locations
        b2.cpu_state = ST_IN;
        step();
        chk("s_ready", b2.ld_ready, 1);
        b2.ld_valid = 1;
        for (int i = 0; i < 6; i++) begin
            b2.ld_data = 8'(8'hC0 + i);
            step();
            chk("s_count", b2.ld_count, (i + 1 > 4) ? 4 : i + 1);
        end
        b2.ld_valid = 0;
        chk("s_full_ready", b2.ld_ready, 0);
        b2.cpu_state = ST_RUN;
        step();
        b2.mem_read = 1;
        for (int i = 0; i < 4; i++) begin
            b2.addr = 16'(i);
            #1;
            chk("s_mem", b2.rdata, 8'hC0 + i);
        end
        b2.mem_read = 0;
        b2.cpu_state = ST_IDLE;
        step();
        b2.cpu_state = ST_IN;
        step();
        chk("s_reenter_count", b2.ld_count, 0);
        chk("s_reenter_ready", b2.ld_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
